// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between one manager-side driver and the SRAM responder.
interface ahb_lite_sram_slave_if;
  logic        hsel_f;
  logic [31:0] haddr_f;
  logic [1:0]  htrans_f;
  logic        hwrite_f;
  logic [2:0]  hsize_f;
  logic [2:0]  hburst_f;
  logic [3:0]  hprot_f;
  logic [31:0] hwdata_f;
  logic        hready_f;
  logic        hreadyout_f;
  logic        hresp_f;
  logic [31:0] hrdata_f;

  modport slave (
    input  hsel_f, haddr_f, htrans_f, hwrite_f, hsize_f, hburst_f, hprot_f,
           hwdata_f, hready_f,
    output hreadyout_f, hresp_f, hrdata_f
  );

  modport master (
    output hsel_f, haddr_f, htrans_f, hwrite_f, hsize_f, hburst_f, hprot_f,
           hwdata_f, hready_f,
    input  hreadyout_f, hresp_f, hrdata_f
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: programmable wait states, byte/half/word access, two-cycle ERROR.
// Optional macro AHB_SLV_PRIV_CHECK_EN rejects user-mode accesses to the upper half of the array.
module ahb_lite_sram_slave #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0,
  parameter int RESET_MEM   = 1
) (
  input logic                  hclk_f,
  input logic                  hrst_f,
  ahb_lite_sram_slave_if.slave bus
);
  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] W_LAST = 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t        r_state, w_state_nx;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [AW-1:0] r_addr;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic          r_write;
  logic          r_pend;
  logic [2:0]    r_wcnt;

  logic          w_can_accept, w_accept, w_err, w_complete;
  logic          w_hreadyout, w_hresp;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_unused;

  assign w_unused     = ^{bus.hburst_f, bus.hprot_f};
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_ERR2);
  assign w_accept     = w_can_accept && bus.hsel_f && bus.hready_f && bus.htrans_f[1];
  // r_pend marks a legal data phase; it completes on the first IDLE cycle.
  assign w_complete   = (r_state == ST_IDLE) && r_pend;

  always_comb begin
    w_err = 1'b0;
    case (bus.hsize_f)
      3'd0:    w_err = 1'b0;
      3'd1:    w_err = bus.haddr_f[0];
      3'd2:    w_err = |bus.haddr_f[1:0];
      default: w_err = 1'b1;
    endcase
    if (|bus.haddr_f[31:AW+2]) w_err = 1'b1;
`ifdef AHB_SLV_PRIV_CHECK_EN
    if (!bus.hprot_f[1] && bus.haddr_f[AW+1]) w_err = 1'b1;
`endif
  end

  always_comb begin
    w_state_nx  = r_state;
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_state_nx = w_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_IDLE);
      end
      ST_WAIT: begin
        w_hreadyout = 1'b0;
        if (r_wcnt == W_LAST) w_state_nx = ST_IDLE;
      end
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        w_hresp = 1'b1;
        if (w_accept)
          w_state_nx = w_err ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_IDLE);
        else
          w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk_f) begin
    if (hrst_f) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_wcnt  <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= (r_state == ST_WAIT) ? r_wcnt + 3'd1 : 3'd0;
      if (w_accept)        r_pend <= !w_err;
      else if (w_complete) r_pend <= 1'b0;
    end
  end

  always_ff @(posedge hclk_f) begin
    if (w_accept) begin
      r_addr  <= bus.haddr_f[AW+1:2];
      r_lane  <= bus.haddr_f[1:0];
      r_size  <= bus.hsize_f[1:0];
      r_write <= bus.hwrite_f;
    end
  end

  // Little-endian lane merge: untouched lanes keep the stored bytes.
  always_comb begin
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
    w_wdata = r_mem[r_addr];
    for (int b = 0; b < 4; b++)
      if (w_be[b]) w_wdata[8*b +: 8] = bus.hwdata_f[8*b +: 8];
  end

  always_ff @(posedge hclk_f) begin
    if (hrst_f) begin
      if (RESET_MEM != 0)
        for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (w_complete && r_write) begin
      r_mem[r_addr] <= w_wdata;
    end
  end

  assign bus.hreadyout_f = w_hreadyout;
  assign bus.hresp_f     = w_hresp;
  assign bus.hrdata_f    = (w_complete && !r_write) ? r_mem[r_addr] : 32'h0;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: a zero-wait and a three-wait instance behind one driver.
module tb_ahb_lite_sram_slave;
  localparam int DEPTH = 256;
`ifdef AHB_SLV_PRIV_CHECK_EN
  localparam bit PRIV = 1'b1;
`else
  localparam bit PRIV = 1'b0;
`endif

  logic hclk_f;
  logic hrst_f;
  initial hclk_f = 1'b0;
  always #5 hclk_f = ~hclk_f;

  logic        tgt;
  logic        m_sel, m_write;
  logic [1:0]  m_trans;
  logic [2:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_prot;

  ahb_lite_sram_slave_if bus0();
  ahb_lite_sram_slave_if bus1();

  assign bus0.hsel_f   = m_sel & ~tgt;
  assign bus1.hsel_f   = m_sel & tgt;
  assign bus0.htrans_f = m_trans;  assign bus1.htrans_f = m_trans;
  assign bus0.hwrite_f = m_write;  assign bus1.hwrite_f = m_write;
  assign bus0.hsize_f  = m_size;   assign bus1.hsize_f  = m_size;
  assign bus0.haddr_f  = m_addr;   assign bus1.haddr_f  = m_addr;
  assign bus0.hwdata_f = m_wdata;  assign bus1.hwdata_f = m_wdata;
  assign bus0.hprot_f  = m_prot;   assign bus1.hprot_f  = m_prot;
  assign bus0.hburst_f = 3'd0;     assign bus1.hburst_f = 3'd1;
  assign bus0.hready_f = bus0.hreadyout_f;
  assign bus1.hready_f = bus1.hreadyout_f;

  ahb_lite_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .RESET_MEM(1)) u_dut0 (
    .hclk_f(hclk_f), .hrst_f(hrst_f), .bus(bus0.slave));
  ahb_lite_sram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .RESET_MEM(1)) u_dut1 (
    .hclk_f(hclk_f), .hrst_f(hrst_f), .bus(bus1.slave));

  logic        o_rdy, o_resp;
  logic [31:0] o_rdata;
  assign o_rdy   = tgt ? bus1.hreadyout_f : bus0.hreadyout_f;
  assign o_resp  = tgt ? bus1.hresp_f     : bus0.hresp_f;
  assign o_rdata = tgt ? bus1.hrdata_f    : bus0.hrdata_f;

  int n_chk = 0;
  int n_fail = 0;
  bit [7:0] model [DEPTH*4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk_f);
    #1;
  endtask

  // Reference rules: size legality, natural alignment, range, optional privilege.
  function automatic bit is_err(input logic [2:0] size, input logic [31:0] addr, input logic [3:0] prot);
    if (size > 3'd2) return 1'b1;
    if ((addr % (32'd1 << size)) != 0) return 1'b1;
    if ((addr >> 2) >= 32'(DEPTH)) return 1'b1;
    if (PRIV && !prot[1] && (addr >> 2) >= 32'(DEPTH / 2)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int base;
    base = int'(addr - (addr % 4));
    return {model[base+3], model[base+2], model[base+1], model[base]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++)
      model[int'(addr) + i] = wdata[8*((int'(addr) + i) % 4) +: 8];
  endtask

  task automatic drive_idle();
    m_sel = 1'b0; m_trans = 2'b00; m_write = 1'b0; m_size = 3'd2; m_addr = 32'h0; m_prot = 4'h3;
  endtask

  task automatic count_waits(output int nwait, output bit dirty);
    nwait = 0; dirty = 1'b0;
    while (!o_rdy && nwait < 16) begin
      if (o_rdata !== 32'h0) dirty = 1'b1;
      nwait++;
      step();
    end
  endtask

  task automatic beat(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] prot,
                      output int nwait, output bit err, output logic [31:0] rdata, output bit dirty);
    m_sel = 1'b1; m_trans = 2'b10; m_write = wr; m_size = size; m_addr = addr; m_prot = prot;
    m_wdata = 32'h0;
    step();
    drive_idle();
    m_wdata = wdata;
    err = o_resp;
    count_waits(nwait, dirty);
    err = err | o_resp;
    rdata = o_rdata;
    step();
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  prot;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit wr, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] prot,
                              input bit exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.prot = prot;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    bit er, dirty;
    logic [31:0] rd;

    tbl.push_back(mk(0, 3'd2, 32'h010, 32'h0,        4'h3, 0, 32'h0));
    tbl.push_back(mk(1, 3'd2, 32'h040, 32'hDEADBEEF, 4'h3, 0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h040, 32'h0,        4'h3, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 3'd2, 32'h040, 32'h11223344, 4'h3, 0, 32'h0));
    tbl.push_back(mk(1, 3'd0, 32'h041, 32'h0000AA00, 4'h3, 0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h040, 32'h0,        4'h3, 0, 32'h1122AA44));
    tbl.push_back(mk(1, 3'd1, 32'h042, 32'h55660000, 4'h3, 0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h040, 32'h0,        4'h3, 0, 32'h5566AA44));
    tbl.push_back(mk(0, 3'd0, 32'h043, 32'h0,        4'h3, 0, 32'h5566AA44));
    tbl.push_back(mk(1, 3'd2, 32'h002, 32'hFFFFFFFF, 4'h3, 1, 32'h0));
    tbl.push_back(mk(1, 3'd2, 32'h400, 32'hFFFFFFFF, 4'h3, 1, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h000, 32'h0,        4'h3, 0, 32'h0));
    tbl.push_back(mk(1, 3'd3, 32'h008, 32'hFFFFFFFF, 4'h3, 1, 32'h0));
    tbl.push_back(mk(1, 3'd1, 32'h045, 32'hFFFFFFFF, 4'h3, 1, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h004, 32'h0,        4'h3, 0, 32'h0));
    tbl.push_back(mk(1, 3'd2, 32'h3FC, 32'hCAFEF00D, 4'h3, 0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h3FC, 32'h0,        4'h3, 0, 32'hCAFEF00D));
    tbl.push_back(mk(1, 3'd2, 32'h320, 32'hA5A5A5A5, 4'h0, PRIV, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h320, 32'h0,        4'h2, 0, PRIV ? 32'h0 : 32'hA5A5A5A5));
    tbl.push_back(mk(1, 3'd2, 32'h320, 32'h12345678, 4'h2, 0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h320, 32'h0,        4'h2, 0, 32'h12345678));
    tbl.push_back(mk(1, 3'd2, 32'h020, 32'h00000077, 4'h0, 0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h020, 32'h0,        4'h0, 0, 32'h00000077));

    // Reset and idle bus
    tgt = 1'b0; m_wdata = 32'h0; drive_idle();
    hrst_f = 1'b1;
    repeat (3) step();
    hrst_f = 1'b0;
    step();
    check("rst0_ready", {31'h0, bus0.hreadyout_f}, 32'h1);
    check("rst0_resp",  {31'h0, bus0.hresp_f},     32'h0);
    check("rst0_rdata", bus0.hrdata_f,             32'h0);
    check("rst1_ready", {31'h0, bus1.hreadyout_f}, 32'h1);
    check("rst1_resp",  {31'h0, bus1.hresp_f},     32'h0);
    check("rst1_rdata", bus1.hrdata_f,             32'h0);

    // Directed vectors on the zero-wait instance
    foreach (tbl[i]) begin
      beat(tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].prot, nw, er, rd, dirty);
      check($sformatf("vec%0d_err", i),   {31'h0, er}, {31'h0, tbl[i].exp_err});
      check($sformatf("vec%0d_waits", i), 32'(nw), tbl[i].exp_err ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      if (tbl[i].wr && !tbl[i].exp_err) model_write(tbl[i].addr, tbl[i].size, tbl[i].wdata);
    end

    // Two-cycle ERROR shape, with the next transfer accepted during ERR2
    m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h002; m_prot = 4'h3;
    step();
    m_write = 1'b0; m_addr = 32'h040;
    check("err1_ready", {31'h0, o_rdy},  32'h0);
    check("err1_resp",  {31'h0, o_resp}, 32'h1);
    check("err1_rdata", o_rdata,         32'h0);
    step();
    check("err2_ready", {31'h0, o_rdy},  32'h1);
    check("err2_resp",  {31'h0, o_resp}, 32'h1);
    check("err2_rdata", o_rdata,         32'h0);
    step();
    drive_idle();
    check("err2_next_ready", {31'h0, o_rdy},  32'h1);
    check("err2_next_resp",  {31'h0, o_resp}, 32'h0);
    check("err2_next_rdata", o_rdata,         model_word(32'h040));
    step();

    // Randomized pipelined traffic on the zero-wait instance against the byte model
    begin
      bit dp_vld, dp_err, dp_wr;
      int err_ph;
      logic [31:0] dp_addr, a;
      logic [2:0] dp_size, sz;
      bit exp_rdy, exp_resp;
      logic [31:0] exp_rd;
      dp_vld = 0; dp_err = 0; dp_wr = 0; err_ph = 0; dp_addr = 0; dp_size = 0;
      for (int c = 0; c < 600; c++) begin
        exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'h0;
        m_wdata = $urandom();
        if (dp_vld) begin
          if (dp_err) begin
            exp_resp = 1'b1;
            if (err_ph == 0) begin exp_rdy = 1'b0; err_ph = 1; end
            else begin dp_vld = 0; err_ph = 0; end
          end else begin
            if (dp_wr) model_write(dp_addr, dp_size, m_wdata);
            else exp_rd = model_word(dp_addr);
            dp_vld = 0;
          end
        end
        check("rnd_ready", {31'h0, o_rdy},  {31'h0, exp_rdy});
        check("rnd_resp",  {31'h0, o_resp}, {31'h0, exp_resp});
        check("rnd_rdata", o_rdata,         exp_rd);
        sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(DEPTH*4 - 16, DEPTH*4 + 15))
                                         : 32'($urandom_range(0, 63));
        if (sz <= 3'd2 && $urandom_range(0, 1) == 1) a = a - (a % (32'd1 << sz));
        m_sel   = ($urandom_range(0, 7) != 0);
        m_trans = 2'($urandom_range(0, 3));
        m_write = 1'($urandom_range(0, 1));
        m_prot  = 4'($urandom_range(0, 15));
        m_size  = sz;
        m_addr  = a;
        if (exp_rdy && m_sel && m_trans[1]) begin
          dp_vld = 1; dp_err = is_err(sz, a, m_prot); dp_wr = m_write; dp_addr = a; dp_size = sz;
          err_ph = 0;
        end
        step();
      end
      drive_idle();
      step();
      step();
    end

    // Three-wait instance: write then pipelined read of the same word
    tgt = 1'b1;
    m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h040; m_prot = 4'h3;
    step();
    drive_idle();
    m_wdata = 32'h0BADF00D;
    count_waits(nw, dirty);
    check("ws3_wr_waits", 32'(nw), 32'd3);
    check("ws3_wr_rdata", o_rdata, 32'h0);
    m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b0; m_size = 3'd2; m_addr = 32'h040;
    step();
    drive_idle();
    m_wdata = 32'h0;
    count_waits(nw, dirty);
    check("ws3_rd_waits",     32'(nw), 32'd3);
    check("ws3_rd_dirty",     {31'h0, dirty}, 32'h0);
    check("ws3_rd_resp",      {31'h0, o_resp}, 32'h0);
    check("ws3_rd_rdata",     o_rdata, 32'h0BADF00D);
    step();
    check("ws3_after_rdata",  o_rdata, 32'h0);

    // Reset asserted during the wait phase of a write
    m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h080;
    step();
    drive_idle();
    m_wdata = 32'h12345678;
    check("rstw_in_wait", {31'h0, o_rdy}, 32'h0);
    step();
    hrst_f = 1'b1;
    step();
    hrst_f = 1'b0;
    check("rstw_ready", {31'h0, o_rdy},  32'h1);
    check("rstw_resp",  {31'h0, o_resp}, 32'h0);
    check("rstw_rdata", o_rdata,         32'h0);
    step();
    beat(1'b0, 3'd2, 32'h080, 32'h0, 4'h3, nw, er, rd, dirty);
    check("rstw_rd_waits", 32'(nw), 32'd3);
    check("rstw_rd_err",   {31'h0, er}, 32'h0);
    check("rstw_rd_rdata", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
